// File: rtl/fifo_stream_pkg.sv
// Shared occupancy type, buffer depth and invariant-check macros for the FIFO read streamer.
`ifndef FIFO_STREAM_PKG_SV
`define FIFO_STREAM_PKG_SV

`define FIFO_STREAM_ASSERT_OCC_LEGAL(clk_s, rst_s, occ_s) \
    a_occ_legal: assert property (@(posedge clk_s) disable iff (rst_s) \
        (3'(occ_s) <= 3'(fifo_stream_pkg::BUF_DEPTH)))

`define FIFO_STREAM_ASSERT_CREDIT(clk_s, rst_s, occ_s, pend_s) \
    a_occ_pend_credit: assert property (@(posedge clk_s) disable iff (rst_s) \
        ((3'(occ_s) + 3'(pend_s)) <= 3'(fifo_stream_pkg::BUF_DEPTH)))

package fifo_stream_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

`endif

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order buffer: head is always the oldest word, occupancy is the state.
module stream_skid_buf2
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output occ_e                  o_occ
);

    occ_e                  r_occ;
    occ_e                  w_occ_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
        end
    end

    // A push while popping in ONE replaces the head; in TWO the tail shifts forward.
    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        case (r_occ)
            OCC_EMPTY: begin
                if (i_push) begin
                    w_head_nxt = i_push_data;
                    w_occ_nxt  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (i_push && i_pop) begin
                    w_head_nxt = i_push_data;
                end else if (i_push) begin
                    w_tail_nxt = i_push_data;
                    w_occ_nxt  = OCC_TWO;
                end else if (i_pop) begin
                    w_occ_nxt  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (i_pop) begin
                    w_head_nxt = r_tail;
                    if (i_push) begin
                        w_tail_nxt = i_push_data;
                    end else begin
                        w_occ_nxt  = OCC_ONE;
                    end
                end
            end
            default: w_occ_nxt = OCC_EMPTY;
        endcase
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_streamer.sv
// FIFO read-side drain engine: credit-based read strobes into a 2-entry buffer, valid/ready output.
// Optional STREAM_LAST_EN adds the m_last port and a burst-index counter.
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
`ifdef STREAM_LAST_EN
    output logic                  m_last,
`endif
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic                  idle
);

    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("BURST_LEN must be at least 1");
    end

    logic                  r_pend;
    logic [CNT_WIDTH-1:0]  r_beat_count;
    logic                  w_pop;
    logic [2:0]            w_credit;
    occ_e                  w_occ;
    logic [DATA_WIDTH-1:0] w_head;

    stream_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_pend),
        .i_push_data (fifo_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    assign m_valid  = (w_occ != OCC_EMPTY);
    assign w_pop    = m_valid && m_ready;
    // Slots committed after this edge; a same-cycle pop frees one, hence the m_ready path.
    assign w_credit = 3'(w_occ) + 3'(r_pend) - 3'(w_pop);
    assign fifo_rd_en = !reset && !fifo_empty && (w_credit < 3'(BUF_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend       <= 1'b0;
            r_beat_count <= '0;
        end else begin
            r_pend <= fifo_rd_en;
            if (w_pop) begin
                r_beat_count <= r_beat_count + CNT_WIDTH'(1);
            end
        end
    end

    assign m_data     = w_head;
    assign beat_count = r_beat_count;
    assign idle       = (w_occ == OCC_EMPTY) && !r_pend && fifo_empty;

`ifdef STREAM_LAST_EN
    localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [IDX_W-1:0] r_burst_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_idx <= '0;
        end else if (w_pop) begin
            if (r_burst_idx == IDX_W'(BURST_LEN - 1)) begin
                r_burst_idx <= '0;
            end else begin
                r_burst_idx <= r_burst_idx + IDX_W'(1);
            end
        end
    end

    assign m_last = m_valid && (r_burst_idx == IDX_W'(BURST_LEN - 1));
`endif

    `FIFO_STREAM_ASSERT_CREDIT(clk, reset, w_occ, r_pend);
    `FIFO_STREAM_ASSERT_OCC_LEGAL(clk, reset, w_occ);

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer with a registered-read FIFO model; covers STREAM_LAST_EN when defined.
module tb_fifo_rd_streamer;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned BL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
`ifdef STREAM_LAST_EN
    logic          m_last;
`endif
    logic [CW-1:0] beat_count;
    logic          idle;

    logic [DW-1:0] mem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    bit            force_empty = 1'b0;
    bit            tb_flush = 1'b0;
    logic [DW-1:0] exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            tb_beats = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    always #5 clk = ~clk;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    // FIFO model with one-cycle registered read latency
    always @(posedge clk) begin
        if (tb_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    fifo_rd_streamer #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
`ifdef STREAM_LAST_EN
        .m_last     (m_last),
`endif
        .beat_count (beat_count),
        .idle       (idle)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr % 256] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    task automatic push_raw(input logic [DW-1:0] d);
        mem[wr_ptr % 256] = d;
        wr_ptr++;
    endtask

    task automatic count_run(output int run);
        run = 0;
        while (m_valid && run < 100) begin
            run++;
            @(negedge clk);
        end
    endtask

`ifdef STREAM_LAST_EN
    task automatic do_reset();
        tick();
        reset    = 1'b1;
        tb_flush = 1'b1;
        exp_q.delete();
        tick();
        tb_flush = 1'b0;
        tick();
        reset    = 1'b0;
    endtask
`endif

    // Monitor: pops the scoreboard on every accepted beat
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                tb_beats   = 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall_hold", 32'(m_data), 32'(data_prev));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got 0x%0h with empty scoreboard", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(m_data), 32'(e));
                    end
                    check("beat_count", 32'(beat_count), 32'(tb_beats));
`ifdef STREAM_LAST_EN
                    check("beat_last", 32'(m_last), 32'((tb_beats % BL) == (BL - 1)));
`endif
                    tb_beats++;
                end
                stall_prev = m_valid && !m_ready;
                data_prev  = m_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        int base;
        int cnt;
        bit found;
        reset   = 1'b1;
        m_ready = 1'b0;

        // Reset held while the FIFO is non-empty
        tick();
        push_raw(8'h11); push_raw(8'h22); push_raw(8'h33);
        @(negedge clk);
        check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset_valid", 32'(m_valid), 32'd0);
        check("reset_data", 32'(m_data), 32'd0);
        check("reset_count", 32'(beat_count), 32'd0);
        check("reset_idle_nonempty", 32'(idle), 32'd0);
`ifdef STREAM_LAST_EN
        check("reset_last", 32'(m_last), 32'd0);
`endif
        tick();
        tb_flush = 1'b1;
        tick();
        tb_flush = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(idle), 32'd1);
        check("rd_en_after_reset", 32'(fifo_rd_en), 32'd0);

        // Single word: strobe in N, beat in N+2
        tick();
        m_ready = 1'b1;
        push(8'hA5);
        @(negedge clk);
        check("single_rd_en", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        check("single_rd_once", 32'(fifo_rd_en), 32'd0);
        check("single_n1_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("single_n2_valid", 32'(m_valid), 32'd1);
        check("single_n2_data", 32'(m_data), 32'hA5);
        @(negedge clk);
        check("single_after_valid", 32'(m_valid), 32'd0);
        check("single_count", 32'(beat_count), 32'd1);
        check("single_idle", 32'(idle), 32'd1);

        // Stream of 32 words at full rate
        tick();
        for (int i = 0; i < 32; i++) push(DW'(i));
        @(negedge clk);
        check("stream_first_rd", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        check("stream_fill", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("stream_first_valid", 32'(m_valid), 32'd1);
        check("stream_first_data", 32'(m_data), 32'h00);
        count_run(run);
        check("stream_run", 32'(run), 32'd32);
        check("stream_count", 32'(beat_count), 32'd33);

        // Back-pressure for 5 cycles after beat 0x03
        tick();
        base = rd_ptr;
        for (int i = 0; i < 12; i++) push(DW'(i));
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_valid && m_data == 8'h03) begin
                found = 1'b1;
                break;
            end
        end
        check("bp_found_03", 32'(found), 32'd1);
        tick();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
            check("bp_valid", 32'(m_valid), 32'd1);
            check("bp_hold_data", 32'(m_data), 32'h04);
        end
        check("bp_words_read", 32'(rd_ptr - base), 32'd6);
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_recover_valid", 32'(m_valid), 32'd1);
        check("bp_recover_data", 32'(m_data), 32'h04);
        count_run(run);
        check("bp_run", 32'(run), 32'd8);
        check("bp_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // FIFO goes empty for 3 cycles after 4 reads
        tick();
        for (int i = 0; i < 8; i++) push(8'h40 + DW'(i));
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_rd_en) cnt++;
            if (cnt == 4) break;
        end
        check("empty_reads_before", 32'(cnt), 32'd4);
        tick();
        force_empty = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("empty_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        check("empty_drained", 32'(m_valid), 32'd0);
        tick();
        force_empty = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        check("empty_resume_data", 32'(m_data), 32'h44);
        count_run(run);
        check("empty_resume_run", 32'(run), 32'd4);
        check("empty_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("empty_final_idle", 32'(idle), 32'd1);

`ifdef STREAM_LAST_EN
        begin
            logic [7:0] mask8;
            logic [3:0] mask4;
            int k;
            // 8 beats after reset: m_last on beats 3 and 7
            do_reset();
            tick();
            for (int i = 0; i < 8; i++) push(8'h80 + DW'(i));
            mask8 = '0;
            k = 0;
            for (int i = 0; i < 60 && k < 8; i++) begin
                @(negedge clk);
                if (m_valid && m_ready) begin
                    mask8[k] = m_last;
                    k++;
                end
            end
            check("last_beats8", 32'(k), 32'd8);
            check("last_mask8", 32'(mask8), 32'h88);

            // Reset after beat 1 restarts the burst index
            tick();
            for (int i = 0; i < 8; i++) push(8'h90 + DW'(i));
            found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (m_valid && m_ready && m_data == 8'h91) begin
                    found = 1'b1;
                    break;
                end
            end
            check("last_found_91", 32'(found), 32'd1);
            do_reset();
            tick();
            for (int i = 0; i < 4; i++) push(8'hA0 + DW'(i));
            mask4 = '0;
            k = 0;
            for (int i = 0; i < 40 && k < 4; i++) begin
                @(negedge clk);
                if (m_valid && m_ready) begin
                    mask4[k] = m_last;
                    k++;
                end
            end
            check("last_beats4", 32'(k), 32'd4);
            check("last_mask4", 32'(mask4), 32'h8);
        end
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_streamer.md
# fifo_rd_streamer

Read-side drain engine for the team's synchronous FIFO. Watches the FIFO `empty` flag, issues `Read_enable`-style strobes, absorbs the FIFO's one-cycle registered read latency, and presents the words on a valid/ready stream with full back-pressure support. It sits between the FIFO read port and any downstream stream consumer. It sustains one word per cycle with no loss or duplication.

## Interface
- DATA_WIDTH, 8: word width; matches the FIFO data width.
- CNT_WIDTH, 16: width of the delivered-beat counter.
- BURST_LEN, 4: beats per burst for `m_last`; only used with STREAM_LAST_EN; must be ≥1.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO read data; valid in the cycle after a read strobe.
- fifo_rd_en  out  1  read strobe to the FIFO; one word per high cycle.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_WIDTH  stream word.
- m_ready  in  1  downstream accept.
- m_last  out  1  last beat of burst; port exists only with STREAM_LAST_EN.
- beat_count  out  CNT_WIDTH  count of accepted beats.
- idle  out  1  high when the buffer is empty, nothing is in flight, and `fifo_empty`=1.

## Operation
- Internal 2-entry in-order buffer with occupancy `occ` (0..2). Also holds a 1-bit `pend` flag: a read was issued last cycle and data arrives this cycle.
- pop = m_valid && m_ready.
- fifo_rd_en = !reset && !fifo_empty && (occ + pend − pop) < 2. This is a combinational path from m_ready to fifo_rd_en, and it is permitted.
- Each cycle:
  - pend' = fifo_rd_en.
  - When pend=1, fifo_data is written at the buffer tail.
  - occ' = occ + pend − pop.
  - The invariant occ + pend ≤ 2 must always hold; an assertion is required.
- Occupancy states:
  - EMPTY (occ=0): m_valid=0.
  - ONE (occ=1): m_valid=1.
  - TWO (occ=2): m_valid=1; no read is issued unless pop=1.
  - Transitions follow the occ' rule above.
- m_data is always the buffer head. While m_valid && !m_ready, m_data and m_last hold stable.
- Simultaneous push and pop in ONE: head is replaced by the arriving word, occ stays 1.
- Simultaneous push and pop in TWO: head advances and the new word takes the tail.
- beat_count increments on pop and wraps modulo 2^CNT_WIDTH.
- fifo_empty rising with pend=1: the in-flight word is still captured. fifo_empty is never re-checked for a word already strobed.
- Reset (any time, including mid-stream): buffer, pend and counters are cleared. The in-flight word is discarded; the FIFO shares the same reset.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, beat_count=0, idle=1 once reset releases with fifo_empty=1.
- Latency: fifo_rd_en high in cycle N → fifo_data valid in N+1 → m_valid=1 with that word in N+2.
- Throughput: with m_ready held high and the FIFO non-empty, one beat per cycle after the 2-cycle fill.
- Back-pressure: after m_ready falls, at most 2 further words are held (buffer full). No fifo_rd_en is issued while occ + pend = 2 and pop = 0.
- Recovery: the first beat after m_ready rises is presented the same cycle with no bubble.

## Configuration
- STREAM_LAST_EN defined:
  - Adds the m_last port and a burst-index counter (0..BURST_LEN−1) that advances on pop.
  - m_last=1 while the head beat has index BURST_LEN−1; with BURST_LEN=1, m_last=1 on every valid beat.
  - Reset clears the index.
- STREAM_LAST_EN undefined: no m_last port and no index counter; all other behaviour is identical.

## Structure
- Package fifo_stream_pkg holds:
  - BUF_DEPTH=2.
  - The occupancy typedef (2-bit: EMPTY/ONE/TWO).
  - The shared assertion macros for the occ + pend invariant.
- One sub-module, stream_skid_buf2: the 2-entry in-order buffer (push, pop, head, occ). The top level contains the credit logic, pend flag, counters and macro-gated m_last.

## Test plan
- Reset: hold reset with fifo_empty=0 → fifo_rd_en=0, m_valid=0, beat_count=0; after release with empty FIFO → idle=1.
- Single word: FIFO preloaded with 0xA5, m_ready=1 → one fifo_rd_en pulse in cycle N; m_valid=1 with m_data=0xA5 in N+2; beat_count=1; idle=1 afterwards.
- Stream: 32 words 0x00..0x1F, m_ready=1 → 32 consecutive beats after 2-cycle latency, in order, beat_count=32.
- Back-pressure: m_ready=0 for 5 cycles after beat 0x03 → exactly 2 extra reads issued, m_data holds 0x04; on release, beats 0x04, 0x05, … continue with no gap, loss or duplicate.
- Empty mid-stream: fifo_empty=1 for 3 cycles after 4 words → no fifo_rd_en while empty; m_valid drops after the buffer drains; the stream resumes in order.
- STREAM_LAST_EN with BURST_LEN=4:
  - 8 words → m_last=1 on beats 3 and 7 only.
  - Reset asserted after beat 1 → the next 4 beats place m_last on the 4th.
